player_bullet: RTL and testbench

PLAYER_BULLET -- requirements
Module: player_bullet

---
 rtl/player_bullet.sv | 171 +++++++++++++++++
 tb/tb_player_bullet.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_bullet.sv
`default_nettype none
// ============================================================================
// Module   : player_bullet
// Purpose  : Single player bullet. Synchronises the fire button, launches a
//            bullet from the player's column, steps it up one row per
//            STEP_CYCLES, retires it on a hit or on leaving the top row and
//            holds off re-arming for COOLDOWN_CYCLES.
// Revision : 1.0  initial release
// ============================================================================
module player_bullet #(
    parameter int STEP_CYCLES     = 360000,
    parameter int COOLDOWN_CYCLES = 3600000
) (
    input  logic       clk_36MHz,
    input  logic       reset,
    input  logic       fire,
    input  logic [4:0] player_x,
    input  logic       hit,
    output logic [4:0] bullet_x,
    output logic [3:0] bullet_y,
    output logic       bullet_active,
    output logic       fired,
    output logic [7:0] hit_count
);

    // Counter widths hold the largest terminal value; +1 keeps width >= 1.
    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [3:0]    LAUNCH_ROW = 4'd14;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    // Declaration initialisers give the same power-up values as reset.
    state_t        state_q         = IDLE;
    logic          sync1_q         = 1'b0;
    logic          sync2_q         = 1'b0;
    logic          dly_q           = 1'b0;
    logic [SW-1:0] step_cnt_q      = '0;
    logic [CW-1:0] cool_cnt_q      = '0;
    logic [4:0]    bullet_x_q      = '0;
    logic [3:0]    bullet_y_q      = '0;
    logic          bullet_active_q = 1'b0;
    logic          fired_q         = 1'b0;
    logic [7:0]    hit_count_q     = '0;

    state_t        state_d;
    logic          sync1_d, sync2_d, dly_d;
    logic [SW-1:0] step_cnt_d;
    logic [CW-1:0] cool_cnt_d;
    logic [4:0]    bullet_x_d;
    logic [3:0]    bullet_y_d;
    logic          bullet_active_d;
    logic          fired_d;
    logic [7:0]    hit_count_d;

    logic          launch_req;
    logic          step;

    assign launch_req = sync2_q & ~dly_q;
    assign step       = (step_cnt_q == STEP_LAST);

    // Next-state logic: fire edge detect, flight stepping, hit/miss retire.
    always_comb begin
        state_d         = state_q;
        sync1_d         = fire;
        sync2_d         = sync1_q;
        dly_d           = sync2_q;
        step_cnt_d      = step_cnt_q;
        cool_cnt_d      = cool_cnt_q;
        bullet_x_d      = bullet_x_q;
        bullet_y_d      = bullet_y_q;
        bullet_active_d = bullet_active_q;
        fired_d         = 1'b0;
        hit_count_d     = hit_count_q;

        case (state_q)
            IDLE: begin
                if (launch_req) begin
                    state_d         = FLYING;
                    bullet_x_d      = player_x;
                    bullet_y_d      = LAUNCH_ROW;
                    bullet_active_d = 1'b1;
                    fired_d         = 1'b1;
                    step_cnt_d      = '0;
                end
            end
            FLYING: begin
                if (hit) begin
                    // A hit outranks a coincident step.
                    state_d         = COOLDOWN;
                    bullet_x_d      = '0;
                    bullet_y_d      = '0;
                    bullet_active_d = 1'b0;
                    hit_count_d     = hit_count_q + 8'd1;
                    cool_cnt_d      = '0;
                end else if (step) begin
                    step_cnt_d = '0;
                    if (bullet_y_q > 4'd1) begin
                        bullet_y_d = bullet_y_q - 4'd1;
                    end else begin
                        // Left the top row without hitting anything.
                        state_d         = COOLDOWN;
                        bullet_x_d      = '0;
                        bullet_y_d      = '0;
                        bullet_active_d = 1'b0;
                        cool_cnt_d      = '0;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + SW'(1);
                end
            end
            COOLDOWN: begin
                if (cool_cnt_q == COOL_LAST) begin
                    state_d    = IDLE;
                    cool_cnt_d = '0;
                end else begin
                    cool_cnt_d = cool_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d         = IDLE;
                bullet_x_d      = '0;
                bullet_y_d      = '0;
                bullet_active_d = 1'b0;
            end
        endcase
    end

    // State and output registers; active-low synchronous reset wins.
    always_ff @(posedge clk_36MHz) begin
        if (!reset) begin
            state_q         <= IDLE;
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            dly_q           <= 1'b0;
            step_cnt_q      <= '0;
            cool_cnt_q      <= '0;
            bullet_x_q      <= '0;
            bullet_y_q      <= '0;
            bullet_active_q <= 1'b0;
            fired_q         <= 1'b0;
            hit_count_q     <= '0;
        end else begin
            state_q         <= state_d;
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            dly_q           <= dly_d;
            step_cnt_q      <= step_cnt_d;
            cool_cnt_q      <= cool_cnt_d;
            bullet_x_q      <= bullet_x_d;
            bullet_y_q      <= bullet_y_d;
            bullet_active_q <= bullet_active_d;
            fired_q         <= fired_d;
            hit_count_q     <= hit_count_d;
        end
    end

    assign bullet_x      = bullet_x_q;
    assign bullet_y      = bullet_y_q;
    assign bullet_active = bullet_active_q;
    assign fired         = fired_q;
    assign hit_count     = hit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_player_bullet.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_bullet
// Purpose  : Self-checking bench for player_bullet with a cycle-level
//            reference model built on elapsed-time arithmetic.
// Revision : 1.0  initial release
// ============================================================================
module tb_player_bullet;

    localparam int STEP = 4;
    localparam int COOL = 8;

    logic       clk_36MHz = 1'b0;
    logic       reset     = 1'b0;
    logic       fire      = 1'b0;
    logic [4:0] player_x  = '0;
    logic       hit       = 1'b0;
    logic [4:0] bullet_x;
    logic [3:0] bullet_y;
    logic       bullet_active;
    logic       fired;
    logic [7:0] hit_count;

    player_bullet #(
        .STEP_CYCLES    (STEP),
        .COOLDOWN_CYCLES(COOL)
    ) dut (
        .clk_36MHz    (clk_36MHz),
        .reset        (reset),
        .fire         (fire),
        .player_x     (player_x),
        .hit          (hit),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .bullet_active(bullet_active),
        .fired        (fired),
        .hit_count    (hit_count)
    );

    always #5 clk_36MHz = ~clk_36MHz;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 idle, 1 flying, 2 cooldown.
    int       m_mode  = 0;
    int       m_cyc   = 0;
    int       m_t0    = 0;
    int       m_tr    = 0;
    int       m_x     = 0;
    int       m_hits  = 0;
    int       m_fired = 0;
    bit       fq[$];

    function automatic int exp_y();
        if (m_mode == 1) return 14 - (m_cyc - m_t0) / STEP;
        return 0;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs present there.
    task automatic model_edge();
        bit launch;
        m_cyc++;
        if (!reset) begin
            m_mode  = 0;
            m_hits  = 0;
            m_fired = 0;
            fq      = '{1'b0, 1'b0, 1'b0};
        end else begin
            // Fire sampled two edges ago high, three edges ago low.
            launch  = fq[$-1] && !fq[$-2];
            m_fired = 0;
            case (m_mode)
                0: if (launch) begin
                    m_mode  = 1;
                    m_t0    = m_cyc;
                    m_x     = int'(player_x);
                    m_fired = 1;
                end
                1: begin
                    if (hit) begin
                        m_hits = (m_hits + 1) % 256;
                        m_mode = 2;
                        m_tr   = m_cyc;
                    end else if (m_cyc - m_t0 == 14 * STEP) begin
                        m_mode = 2;
                        m_tr   = m_cyc;
                    end
                end
                default: if (m_cyc - m_tr == COOL) m_mode = 0;
            endcase
            fq.push_back(fire);
            if (fq.size() > 8) void'(fq.pop_front());
        end
    endtask

    task automatic check_all();
        chk("bullet_x", int'(bullet_x), (m_mode == 1) ? m_x : 0);
        chk("bullet_y", int'(bullet_y), exp_y());
        chk("bullet_active", int'(bullet_active), (m_mode == 1) ? 1 : 0);
        chk("fired", int'(fired), m_fired);
        chk("hit_count", int'(hit_count), m_hits);
    endtask

    task automatic tick();
        @(posedge clk_36MHz);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wait_mode(input int target, input int budget);
        int n = 0;
        while (m_mode != target && n < budget) begin
            tick();
            n++;
        end
        if (m_mode != target) chk("wait_mode_timeout", m_mode, target);
    endtask

    initial begin
        int n;
        fq = '{1'b0, 1'b0, 1'b0};

        // Power-up values before any clock edge.
        #1;
        check_all();

        tick();
        tick();
        reset = 1'b1;
        tick();

        // Launch with fire held: active on the third edge seeing fire high.
        player_x = 5'd7;
        fire     = 1'b1;
        tick();
        chk("pre_launch_1", int'(bullet_active), 0);
        tick();
        chk("pre_launch_2", int'(bullet_active), 0);
        tick();
        chk("launch_active", int'(bullet_active), 1);
        chk("launch_x", int'(bullet_x), 7);
        chk("launch_y", int'(bullet_y), 14);
        chk("launch_fired", int'(fired), 1);
        player_x = 5'd3;
        tick();
        chk("fired_pulse_end", int'(fired), 0);
        tick();
        tick();
        tick();
        chk("first_step_y", int'(bullet_y), 13);
        chk("x_held", int'(bullet_x), 7);

        // Uncontested flight with fire held throughout: miss then cooldown.
        wait_mode(2, 80);
        chk("miss_y", int'(bullet_y), 0);
        chk("miss_hits", int'(hit_count), 0);
        wait_mode(0, 20);
        for (int i = 0; i < 6; i++) tick();
        chk("held_no_relaunch", int'(bullet_active), 0);

        // Release and re-press in IDLE gives a second launch.
        fire = 1'b0;
        tick();
        tick();
        tick();
        fire = 1'b1;
        wait_mode(1, 10);
        chk("second_launch", int'(bullet_active), 1);

        // Fire edge during cooldown is discarded, not queued.
        fire = 1'b0;
        wait_mode(2, 80);
        tick();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        wait_mode(0, 20);
        for (int i = 0; i < 6; i++) tick();
        chk("cooldown_fire_dropped", int'(bullet_active), 0);

        // Hit coinciding with the step out of row 5; held hit counts once.
        fire = 1'b1;
        wait_mode(1, 10);
        fire = 1'b0;
        n = 0;
        while (!(m_mode == 1 && exp_y() == 5 && (m_cyc - m_t0) % STEP == STEP - 1)
               && n < 80) begin
            tick();
            n++;
        end
        chk("reach_row5", exp_y(), 5);
        hit = 1'b1;
        tick();
        chk("hit_step_y", int'(bullet_y), 0);
        chk("hit_step_active", int'(bullet_active), 0);
        chk("hit_step_count", int'(hit_count), 1);
        for (int i = 0; i < 10; i++) tick();
        hit = 1'b0;
        chk("held_hit_count", int'(hit_count), 1);

        // Accumulate hits up to 255, then one more wraps to 0.
        wait_mode(0, 20);
        n = 0;
        while (m_hits != 255 && n < 300) begin
            fire     = 1'b1;
            player_x = 5'($urandom_range(19, 0));
            wait_mode(1, 10);
            fire = 1'b0;
            tick();
            hit = 1'b1;
            tick();
            hit = 1'b0;
            wait_mode(0, 20);
            n++;
        end
        chk("count_255", int'(hit_count), 255);
        fire = 1'b1;
        wait_mode(1, 10);
        fire = 1'b0;
        hit  = 1'b1;
        tick();
        hit  = 1'b0;
        chk("count_wrap", int'(hit_count), 0);
        wait_mode(0, 20);

        // Reset mid-flight at row 9 aborts; a fresh edge then launches.
        fire = 1'b1;
        wait_mode(1, 10);
        n = 0;
        while (exp_y() != 9 && n < 80) begin
            tick();
            n++;
        end
        chk("reach_row9", int'(bullet_y), 9);
        reset = 1'b0;
        tick();
        chk("rst_active", int'(bullet_active), 0);
        chk("rst_y", int'(bullet_y), 0);
        chk("rst_x", int'(bullet_x), 0);
        reset = 1'b1;
        fire  = 1'b0;
        tick();
        fire = 1'b1;
        wait_mode(1, 10);
        chk("post_reset_launch", int'(bullet_active), 1);

        // Random phase: slowly varying fire, sparse hits, rare resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7, 0) == 0) fire = ~fire;
            hit      = ($urandom_range(15, 0) == 0);
            player_x = 5'($urandom_range(19, 0));
            reset    = ($urandom_range(499, 0) != 0);
            tick();
        end
        reset = 1'b1;
        hit   = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
